// File: rtl/fir_pkg.sv
// Shared types and constants for fir_mac_filter: FSM state encoding, the default
// 5-tap coefficient set, and the clamp helper used when FIR_SATURATE_EN is defined.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MAC    = 2'd1,
        OUT_LD = 2'd2,
        HOLD   = 2'd3
    } fir_state_t;

    localparam int DEF_TAPS = 5;
    localparam int DEF_COEF [DEF_TAPS] = '{5, 31, -7, 31, 5};

    // Working width of the clamp helper; the accumulator must not exceed it.
    localparam int SAT_W = 64;

    function automatic logic signed [SAT_W-1:0] fir_sat(
        input logic signed [SAT_W-1:0] v,
        input int                      w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered signed multiply-accumulate. Synchronous clear has priority over enable;
// the product is sign-extended into the accumulator at full precision.
module fir_mac #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 6,
    parameter int ACC_W  = 25
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [COEF_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;

    assign prod = PROD_W'(a_i) * PROD_W'(b_i);

    // NOTE: every variable driven from always_comb gets a default first, so no latch can form.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // NOTE: sequential state is only ever updated with non-blocking assignments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR: one MAC walks all taps per accepted sample, valid/ready on both sides.
// Optional build macro FIR_SATURATE_EN clamps the scaled output instead of wrapping it.
module fir_mac_filter
    import fir_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 6,
    parameter int TAPS      = 5,
    parameter int OUT_SHIFT = 0,
    parameter int ACC_W     = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATA_W-1:0]  out_data,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]  coef_data,
    output logic                      busy
);

    localparam int IDX_W = $clog2(TAPS);

    fir_state_t state_q;
    fir_state_t state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    logic signed [DATA_W-1:0] x_q [TAPS];
    logic signed [COEF_W-1:0] c_q [TAPS];
    logic signed [DATA_W-1:0] out_data_q;

    logic                     accept;
    logic                     coef_wr;
    logic                     last_tap;
    logic                     mac_en;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_shifted;
    logic signed [DATA_W-1:0] scaled;

    function automatic logic signed [COEF_W-1:0] coef_default(input int k);
        if (TAPS == DEF_TAPS) begin
            return COEF_W'(DEF_COEF[k]);
        end
        return (k == 0) ? COEF_W'(1) : '0;
    endfunction

    assign accept   = (state_q == IDLE) && in_valid;
    assign coef_wr  = (state_q == IDLE) && coef_we && (int'(coef_addr) < TAPS);
    assign last_tap = (int'(idx_q) == TAPS - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = MAC;
                    idx_d   = '0;
                end
            end
            MAC: begin
                idx_d = idx_q + IDX_W'(1);
                if (last_tap) begin
                    state_d = OUT_LD;
                end
            end
            OUT_LD: state_d = HOLD;
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        mac_en    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            MAC:     mac_en    = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // NOTE: the coefficient bank and delay line are reset explicitly; a reset must restore defaults.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                c_q[k] <= coef_default(k);
            end
            out_data_q <= '0;
        end else begin
            // The write lands on the accepting edge, so that sample already sees it.
            if (coef_wr) begin
                c_q[coef_addr] <= coef_data;
            end
            if (accept) begin
                x_q[0] <= in_data;
                for (int k = 1; k < TAPS; k++) begin
                    x_q[k] <= x_q[k-1];
                end
            end
            if (state_q == OUT_LD) begin
                out_data_q <= scaled;
            end
        end
    end

    fir_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr_i (accept),
        .en_i  (mac_en),
        .a_i   (x_q[idx_q]),
        .b_i   (c_q[idx_q]),
        .acc_o (acc)
    );

    assign acc_shifted = acc >>> OUT_SHIFT;

`ifdef FIR_SATURATE_EN
    assign scaled = DATA_W'(fir_sat(SAT_W'(acc_shifted), DATA_W));
`else
    assign scaled = DATA_W'(acc_shifted);
`endif

    assign out_data = out_data_q;

endmodule

// File: tb/tb_fir_mac_filter.sv
// Self-checking bench for fir_mac_filter: impulse/step/overflow tables, coefficient
// reload, backpressure, reset mid-MAC, and random data against a sum-of-products model.
module tb_fir_mac_filter;

    localparam int DATA_W    = 16;
    localparam int COEF_W    = 6;
    localparam int TAPS      = 5;
    localparam int OUT_SHIFT = 0;
    localparam int AW        = $clog2(TAPS);
    localparam int LAT       = TAPS + 1;
`ifdef FIR_SATURATE_EN
    localparam longint OVF_EXP = 32767;
`else
    localparam longint OVF_EXP = 32703;
`endif
    localparam longint DEF_C [TAPS] = '{5, 31, -7, 31, 5};

    typedef struct {
        longint din;
        longint exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic in_valid;
    logic in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic coef_we;
    logic [AW-1:0] coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic busy;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;

    longint hist   [TAPS];
    longint coef_m [TAPS];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_mac_filter #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .TAPS      (TAPS),
        .OUT_SHIFT (OUT_SHIFT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy)
    );

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < TAPS; k++) begin
            hist[k]   = 0;
            coef_m[k] = DEF_C[k];
        end
    endfunction

    function automatic void model_accept(input longint d);
        for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = d;
    endfunction

    function automatic longint model_y();
        longint s;
        logic signed [DATA_W-1:0] t;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += hist[k] * coef_m[k];
        s = s >>> OUT_SHIFT;
`ifdef FIR_SATURATE_EN
        if (s > (64'sd1 <<< (DATA_W - 1)) - 1) s = (64'sd1 <<< (DATA_W - 1)) - 1;
        if (s < -(64'sd1 <<< (DATA_W - 1))) s = -(64'sd1 <<< (DATA_W - 1));
`else
        t = s[DATA_W-1:0];
        s = t;
`endif
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic write_coef(input int a, input longint v);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        coef_we   = 1'b1;
        coef_addr = AW'(a);
        coef_data = COEF_W'(v);
        if (a < TAPS) coef_m[a] = v;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // wmode: 0 none, 1 coefficient write on the accepting edge, 2 write attempt during MAC.
    task automatic run_sample(input longint d, input int wmode, input int waddr, input longint wdata,
                              output longint y, output int lat);
        int n;
        int unsigned acc_cyc;
        y   = 0;
        lat = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = DATA_W'(d);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        if (wmode == 1) begin
            coef_we   = 1'b1;
            coef_addr = AW'(waddr);
            coef_data = COEF_W'(wdata);
            coef_m[waddr] = wdata;
        end
        model_accept(d);
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        if (wmode == 2) begin
            @(negedge clk);
            coef_we   = 1'b1;
            coef_addr = AW'(waddr);
            coef_data = COEF_W'(wdata);
            @(negedge clk);
            coef_we = 1'b0;
        end
        while (!out_valid && (cyc - acc_cyc) < 100) begin
            @(posedge clk);
            #1;
        end
        if (!out_valid) check("out_timeout", 0, 1);
        lat = int'(cyc - acc_cyc);
        y   = out_data;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t   imp [6];
        vec_t   stp [6];
        longint rel [5];
        longint y;
        longint y1;
        longint d;
        int     lat;
        bit     stable;
        logic signed [DATA_W-1:0] r;

        imp = '{'{1, 5}, '{0, 31}, '{0, -7}, '{0, 31}, '{0, 5}, '{0, 0}};
        stp = '{'{100, 500}, '{100, 3600}, '{100, 2900}, '{100, 6000}, '{100, 6500}, '{100, 6500}};
        rel = '{5, 31, 0, 31, 5};

        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        reset = 1'b0;

        foreach (imp[i]) begin
            run_sample(imp[i].din, 0, 0, 0, y, lat);
            check($sformatf("impulse[%0d]", i), y, imp[i].exp);
            check($sformatf("impulse_lat[%0d]", i), lat, LAT);
        end

        foreach (stp[i]) begin
            run_sample(stp[i].din, 0, 0, 0, y, lat);
            check($sformatf("step[%0d]", i), y, stp[i].exp);
            check($sformatf("step_lat[%0d]", i), lat, LAT);
        end

        for (int i = 0; i < 6; i++) begin
            run_sample(32767, 0, 0, 0, y, lat);
            check($sformatf("ovf_model[%0d]", i), y, model_y());
        end
        check("ovf_steady", y, OVF_EXP);

        do_reset();
        write_coef(2, 0);
        for (int i = 0; i < 5; i++) begin
            run_sample((i == 0) ? 1 : 0, (i == 1) ? 2 : 0, 2, 9, y, lat);
            check($sformatf("reload[%0d]", i), y, rel[i]);
        end

        do_reset();
        run_sample(1, 1, 0, -3, y, lat);
        check("wr_with_accept", y, -3);
        run_sample(0, 0, 0, 0, y, lat);
        check("wr_with_accept_next", y, 31);

        do_reset();
        out_ready = 1'b0;
        run_sample(321, 0, 0, 0, y1, lat);
        check("bp_first", y1, model_y());
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = DATA_W'(-77);
        stable   = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!out_valid || out_data !== DATA_W'(y1) || in_ready || !busy) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        out_ready = 1'b1;
        run_sample(-77, 0, 0, 0, y, lat);
        check("bp_pending", y, model_y());

        @(negedge clk);
        in_valid = 1'b1;
        in_data  = DATA_W'(1234);
        for (int n = 0; n < 100 && !in_ready; n++) @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("mac_busy", busy, 1);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midmac_out_valid", out_valid, 0);
        check("midmac_busy", busy, 0);
        check("midmac_in_ready", in_ready, 1);
        check("midmac_out_data", out_data, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        foreach (imp[i]) begin
            run_sample(imp[i].din, 0, 0, 0, y, lat);
            check($sformatf("post_reset[%0d]", i), y, imp[i].exp);
        end

        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, longint'($urandom_range(63)) - 32);
        for (int i = 0; i < 25; i++) begin
            r = DATA_W'($urandom);
            d = r;
            if ($urandom_range(4) == 0)
                run_sample(d, 1, int'($urandom_range(TAPS - 1)), longint'($urandom_range(63)) - 32, y, lat);
            else
                run_sample(d, 0, 0, 0, y, lat);
            check($sformatf("random[%0d]", i), y, model_y());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
